// File: rtl/mfb_pkg.sv
// rtl/mfb_pkg.sv - shared opcodes, FSM encoding and geometry for matrix_frame_buffer
package mfb_pkg;

    localparam int MFB_ROWS = 8;
    localparam int MFB_COLS = 16;
    localparam int MFB_BITS = MFB_ROWS * MFB_COLS;

    localparam logic [2:0] OP_WRROW  = 3'b000;
    localparam logic [2:0] OP_SETPX  = 3'b001;
    localparam logic [2:0] OP_CLRPX  = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_SWAP   = 3'b100;
    localparam logic [2:0] OP_SETDIG = 3'b101;
    localparam logic [2:0] OP_SCROLL = 3'b110;
    localparam logic [2:0] OP_NOP    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEARING  = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } mfb_state_e;

endpackage

// File: rtl/mfb_row_bank.sv
// rtl/mfb_row_bank.sv - 8x16 register array with sync clear-all, parallel load and one-row write
import mfb_pkg::*;

module mfb_row_bank (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [2:0]          wr_row_i,
    input  logic [15:0]         wr_data_i,
    input  logic                ld_en_i,
    input  logic [MFB_BITS-1:0] ld_data_i,
    output logic [MFB_BITS-1:0] rows_o
);

    logic [MFB_BITS-1:0] rows_q;

    // Clear wins over a whole-array load, which wins over a single-row write.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            rows_q <= '0;
        end else if (ld_en_i) begin
            rows_q <= ld_data_i;
        end else if (wr_en_i) begin
            rows_q[{wr_row_i, 4'b0000} +: MFB_COLS] <= wr_data_i;
        end
    end

    assign rows_o = rows_q;

endmodule

// File: rtl/matrix_frame_buffer.sv
// rtl/matrix_frame_buffer.sv - double-buffered LED matrix frame store; MFB_SCROLL_EN enables SCROLL
import mfb_pkg::*;

module matrix_frame_buffer #(
    parameter int SWAP_TIMEOUT = 0,
    parameter int TO_W         = 24
) (
    input  logic        clockin,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_row,
    input  logic [3:0]  cmd_col,
    input  logic [15:0] cmd_data,
    input  logic        frame_sync,
    output logic [15:0] row0,
    output logic [15:0] row1,
    output logic [15:0] row2,
    output logic [15:0] row3,
    output logic [15:0] row4,
    output logic [15:0] row5,
    output logic [15:0] row6,
    output logic [15:0] row7,
    output logic [3:0]  sev_seg,
    output logic        busy,
    output logic        swap_done
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SWAP_TIMEOUT - 1);

    mfb_state_e          state_q;
    logic [2:0]          clr_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [3:0]          back_dig_q;
    logic [3:0]          front_dig_q;
    logic                ready_q;
    logic                busy_q;
    logic                swap_done_q;

    logic [MFB_BITS-1:0] back_rows;
    logic [MFB_BITS-1:0] front_rows;
    logic [15:0]         cur_row;
    logic                accept;
    logic                timeout_hit;
    logic                swap_fire;

    logic                bk_wr_en_d;
    logic [2:0]          bk_wr_row_d;
    logic [15:0]         bk_wr_data_d;
    logic                bk_ld_en_d;
    logic [MFB_BITS-1:0] bk_ld_data_d;

    assign accept      = cmd_valid && ready_q;
    assign cur_row     = back_rows[{cmd_row, 4'b0000} +: MFB_COLS];
    assign timeout_hit = (SWAP_TIMEOUT != 0) && (to_cnt_q == TO_LAST);
    assign swap_fire   = (state_q == ST_SWAP_WAIT) && (frame_sync || timeout_hit);

    // Back-buffer write port: row zeroing while clearing, else the accepted edit command.
    always_comb begin
        bk_wr_en_d   = 1'b0;
        bk_wr_row_d  = cmd_row;
        bk_wr_data_d = cmd_data;
        bk_ld_en_d   = 1'b0;
        bk_ld_data_d = back_rows;
        if (state_q == ST_CLEARING) begin
            bk_wr_en_d   = 1'b1;
            bk_wr_row_d  = clr_cnt_q;
            bk_wr_data_d = '0;
        end else if (accept) begin
            case (cmd_op)
                OP_WRROW: bk_wr_en_d = 1'b1;
                OP_SETPX: begin
                    bk_wr_en_d   = 1'b1;
                    bk_wr_data_d = cur_row | (16'd1 << cmd_col);
                end
                OP_CLRPX: begin
                    bk_wr_en_d   = 1'b1;
                    bk_wr_data_d = cur_row & ~(16'd1 << cmd_col);
                end
`ifdef MFB_SCROLL_EN
                OP_SCROLL: begin
                    bk_ld_en_d = 1'b1;
                    for (int r = 0; r < MFB_ROWS; r++) begin
                        bk_ld_data_d[r*MFB_COLS +: MFB_COLS] =
                            {back_rows[r*MFB_COLS +: MFB_COLS-1], back_rows[r*MFB_COLS + MFB_COLS-1]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    mfb_row_bank u_back (
        .clk_i     (clockin),
        .clr_i     (reset),
        .wr_en_i   (bk_wr_en_d),
        .wr_row_i  (bk_wr_row_d),
        .wr_data_i (bk_wr_data_d),
        .ld_en_i   (bk_ld_en_d),
        .ld_data_i (bk_ld_data_d),
        .rows_o    (back_rows)
    );

    mfb_row_bank u_front (
        .clk_i     (clockin),
        .clr_i     (reset),
        .wr_en_i   (1'b0),
        .wr_row_i  (3'd0),
        .wr_data_i (16'd0),
        .ld_en_i   (swap_fire),
        .ld_data_i (back_rows),
        .rows_o    (front_rows)
    );

    // Command FSM with registered handshake/status outputs and the digit registers.
    always_ff @(posedge clockin) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            to_cnt_q    <= '0;
            back_dig_q  <= '0;
            front_dig_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_SETDIG: back_dig_q <= cmd_data[3:0];
                            OP_CLEAR: begin
                                state_q   <= ST_CLEARING;
                                clr_cnt_q <= '0;
                                ready_q   <= 1'b0;
                                busy_q    <= 1'b1;
                            end
                            OP_SWAP: begin
                                state_q  <= ST_SWAP_WAIT;
                                to_cnt_q <= '0;
                                ready_q  <= 1'b0;
                                busy_q   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEARING: begin
                    clr_cnt_q <= clr_cnt_q + 3'd1;
                    if (clr_cnt_q == 3'd7) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SWAP_WAIT: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (swap_fire) begin
                        front_dig_q <= back_dig_q;
                        swap_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign swap_done = swap_done_q;
    assign sev_seg   = front_dig_q;
    assign row0      = front_rows[0*MFB_COLS +: MFB_COLS];
    assign row1      = front_rows[1*MFB_COLS +: MFB_COLS];
    assign row2      = front_rows[2*MFB_COLS +: MFB_COLS];
    assign row3      = front_rows[3*MFB_COLS +: MFB_COLS];
    assign row4      = front_rows[4*MFB_COLS +: MFB_COLS];
    assign row5      = front_rows[5*MFB_COLS +: MFB_COLS];
    assign row6      = front_rows[6*MFB_COLS +: MFB_COLS];
    assign row7      = front_rows[7*MFB_COLS +: MFB_COLS];

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// tb/tb_matrix_frame_buffer.sv - scoreboard bench for matrix_frame_buffer with SWAP_TIMEOUT=20
module tb_matrix_frame_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_row;
    logic [3:0]  cmd_col;
    logic [15:0] cmd_data;
    logic        frame_sync;
    logic [15:0] row0, row1, row2, row3, row4, row5, row6, row7;
    logic [3:0]  sev_seg;
    logic        busy;
    logic        swap_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [127:0] rows;
        logic [3:0]   dig;
        int           cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_back[8];
    logic [3:0]  m_dig;

    matrix_frame_buffer #(.SWAP_TIMEOUT(20), .TO_W(24)) dut (
        .clockin(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
        .frame_sync(frame_sync), .row0(row0), .row1(row1), .row2(row2), .row3(row3),
        .row4(row4), .row5(row5), .row6(row6), .row7(row7), .sev_seg(sev_seg),
        .busy(busy), .swap_done(swap_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int r = 0; r < 8; r++) f[r*16 +: 16] = m_back[r];
        return f;
    endfunction

    function automatic logic [127:0] front_flat();
        return {row7, row6, row5, row4, row3, row2, row1, row0};
    endfunction

    // Monitor: every swap_done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && swap_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_swap", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("swap_rows", front_flat(), e.rows);
                chk("swap_digit", 128'(sev_seg), 128'(e.dig));
                chk("swap_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // Issue one command at a negedge; returns the cycle count seen while driving.
    task automatic send(input logic [2:0] op, input logic [2:0] r, input logic [3:0] c,
                        input logic [15:0] d, input logic fs, output int pcyc);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_wait", 128'd0, 128'd1);
        pcyc = cyc;
        cmd_valid = 1'b1; cmd_op = op; cmd_row = r; cmd_col = c; cmd_data = d; frame_sync = fs;
        @(negedge clk);
        cmd_valid = 1'b0; frame_sync = 1'b0;
        case (op)
            3'b000: m_back[r] = d;
            3'b001: m_back[r][c] = 1'b1;
            3'b010: m_back[r][c] = 1'b0;
            3'b011: for (int i = 0; i < 8; i++) m_back[i] = 16'h0000;
            3'b101: m_dig = d[3:0];
`ifdef MFB_SCROLL_EN
            3'b110: for (int i = 0; i < 8; i++) m_back[i] = {m_back[i][14:0], m_back[i][15]};
`endif
            default: ;
        endcase
    endtask

    task automatic push_exp(input int c);
        exp_t e;
        e.rows = model_flat();
        e.dig  = m_dig;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // SWAP followed by a frame_sync pulse after 'gap' idle cycles.
    task automatic swap_sync(input int gap);
        int p;
        send(3'b100, 3'd0, 4'd0, 16'h0, 1'b0, p);
        repeat (gap) @(negedge clk);
        push_exp(cyc + 1);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    initial begin
        int p;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0;
        cmd_data = '0; frame_sync = 1'b0; m_dig = 4'h0;
        for (int i = 0; i < 8; i++) m_back[i] = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 128'(cmd_ready), 128'd1);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_swap_done", 128'(swap_done), 128'd0);
        chk("reset_rows", front_flat(), 128'd0);
        chk("reset_digit", 128'(sev_seg), 128'd0);

        // WRROW + SETDIG, then a synced swap.
        send(3'b000, 3'd3, 4'd0, 16'hA5C3, 1'b0, p);
        send(3'b101, 3'd0, 4'd0, 16'hFFF9, 1'b0, p);
        chk("idle_busy", 128'(busy), 128'd0);
        swap_sync(3);
        drain("drain_wrrow");
        chk("row3_after_swap", 128'(row3), 128'hA5C3);

        // Pixel set/clear.
        send(3'b001, 3'd0, 4'd15, 16'h0, 1'b0, p);
        send(3'b010, 3'd0, 4'd15, 16'h0, 1'b0, p);
        send(3'b001, 3'd0, 4'd0, 16'h0, 1'b0, p);
        send(3'b111, 3'd5, 4'd5, 16'hFFFF, 1'b0, p);
        swap_sync(1);
        drain("drain_px");
        chk("row0_px", 128'(row0), 128'h0001);

        // Fill, swap, then CLEAR: front must hold while back is wiped.
        for (int i = 0; i < 8; i++) send(3'b000, 3'(i), 4'd0, 16'hFFFF, 1'b0, p);
        swap_sync(2);
        drain("drain_fill");
        send(3'b011, 3'd0, 4'd0, 16'h0, 1'b0, p);
        for (int i = 0; i < 7; i++) begin
            chk("clear_ready_low", 128'(cmd_ready), 128'd0);
            chk("clear_busy_high", 128'(busy), 128'd1);
            @(negedge clk);
        end
        chk("clear_ready_low_last", 128'(cmd_ready), 128'd0);
        @(negedge clk);
        chk("clear_ready_back", 128'(cmd_ready), 128'd1);
        chk("front_held", front_flat(), {8{16'hFFFF}});
        swap_sync(2);
        drain("drain_clear");

        // frame_sync in the acceptance cycle must be ignored.
        send(3'b000, 3'd5, 4'd0, 16'h1234, 1'b0, p);
        send(3'b100, 3'd0, 4'd0, 16'h0, 1'b1, p);
        repeat (5) @(negedge clk);
        chk("ignored_sync_busy", 128'(busy), 128'd1);
        chk("ignored_sync_front", 128'(row5), 128'h0000);
        push_exp(cyc + 1);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        drain("drain_ignored");

        // Forced swap after 20 cycles without frame_sync.
        send(3'b000, 3'd1, 4'd0, 16'hBEEF, 1'b0, p);
        send(3'b100, 3'd0, 4'd0, 16'h0, 1'b0, p);
        push_exp(p + 21);
        drain("drain_timeout");

        // SCROLL (rotate) or NOP depending on build.
        send(3'b000, 3'd2, 4'd0, 16'h8001, 1'b0, p);
        send(3'b110, 3'd0, 4'd0, 16'h0, 1'b0, p);
        swap_sync(0);
        drain("drain_scroll");
`ifdef MFB_SCROLL_EN
        chk("scroll_row2", 128'(row2), 128'h0003);
`else
        chk("scroll_row2", 128'(row2), 128'h8001);
`endif

        // Reset four cycles into CLEARING.
        send(3'b011, 3'd0, 4'd0, 16'h0, 1'b0, p);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rows", front_flat(), 128'd0);
        chk("abort_digit", 128'(sev_seg), 128'd0);
        chk("abort_ready", 128'(cmd_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
